noc_frame_store_mvc: RTL

- Multi-VC store-and-forward frame buffer that sits directly on one NoC router port. It is the parametrised successor of the single-channel DDR frame-buffer endpoint.
- Accepts multi-flit frames on NUM_VC virtual channels and buffers each VC in its own circular buffer.
- Releases only complete frames, arbitrating round-robin between VCs, and returns each frame to the node that sent it.
- Drops oversize, orphaned and truncated frames by pointer rollback and counts the drops.

---
 rtl/noc_frame_store_mvc.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_frame_store_mvc.sv
// Multi-VC store-and-forward frame buffer for one NoC router port.
// Each VC owns a circular buffer; only complete frames are released, VCs are
// served round-robin a whole frame at a time, and bad frames are rolled back.
module noc_frame_store_mvc #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned PORT_WIDTH      = 600,
  parameter int unsigned NUM_VC          = 2,
  parameter int unsigned NOC_RADIX       = 16,
  parameter int unsigned BUF_DEPTH       = 64,
  parameter int unsigned MAX_FRAME_FLITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORT_WIDTH-1:0] i_data_in,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  output logic [PORT_WIDTH-1:0] o_data_out,
  output logic                  o_valid_out,
  input  logic                  o_ready_in,
  output logic [15:0]           o_drop_count
);

  localparam int unsigned VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned AW      = $clog2(NOC_RADIX);
  localparam int unsigned IW      = $clog2(BUF_DEPTH);
  localparam int unsigned PW      = IW + 1;
  localparam int unsigned LW      = $clog2(MAX_FRAME_FLITS + 1);
  localparam int unsigned EW      = DATA_WIDTH + 2 + AW;
  localparam int unsigned SOP_BIT = DATA_WIDTH;
  localparam int unsigned EOP_BIT = DATA_WIDTH + 1;
  localparam int unsigned VC_LO   = DATA_WIDTH + 2;
  localparam int unsigned SRC_LO  = VC_LO + VCW;

  // Stored entry: {source, eop, sop, payload}
  logic [EW-1:0]     mem_q [NUM_VC][BUF_DEPTH];

  logic [PW-1:0]     wc_q [NUM_VC];
  logic [PW-1:0]     wc_d [NUM_VC];
  logic [PW-1:0]     ws_q [NUM_VC];
  logic [PW-1:0]     ws_d [NUM_VC];
  logic [PW-1:0]     r_q  [NUM_VC];
  logic [PW-1:0]     r_d  [NUM_VC];
  logic [PW-1:0]     fc_q [NUM_VC];
  logic [PW-1:0]     fc_d [NUM_VC];
  logic [LW-1:0]     len_q [NUM_VC];
  logic [LW-1:0]     len_d [NUM_VC];
  logic [NUM_VC-1:0] in_frame_q, in_frame_d;
  logic [NUM_VC-1:0] skip_q, skip_d;
  logic [NUM_VC-1:0] commit, rd_eop;

  logic              grant_q, grant_d;
  logic [VCW-1:0]    grant_vc_q, grant_vc_d;
  logic [VCW-1:0]    arb_ptr_q, arb_ptr_d;
  logic [PORT_WIDTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              ready_q, ready_d;
  logic [15:0]       drop_q, drop_d;
  logic              drop_inc;

  logic              acc, in_sop, in_eop;
  logic [VCW-1:0]    in_vc;
  logic [EW-1:0]     in_entry;
  logic              wr_en;
  logic [VCW-1:0]    wr_vc;
  logic [IW-1:0]     wr_addr;

  logic              found, sel_ok, sel_avail, load;
  logic [VCW-1:0]    pick, sel_vc;
  logic [EW-1:0]     sel_entry;
  logic [PW-1:0]     occ;
  logic              any_full;
  logic              unused_upper;

  assign acc          = i_valid_in & ready_q;
  assign in_sop       = i_data_in[SOP_BIT];
  assign in_eop       = i_data_in[EOP_BIT];
  assign in_vc        = i_data_in[VC_LO +: VCW];
  assign in_entry     = {i_data_in[SRC_LO +: AW], i_data_in[EOP_BIT:0]};
  assign unused_upper = ^i_data_in[PORT_WIDTH-1:SRC_LO+AW];

  assign i_ready_out  = ready_q;
  assign o_data_out   = out_data_q;
  assign o_valid_out  = out_valid_q;
  assign o_drop_count = drop_q;

  // Write side: frame tracking, speculative writes, commit and rollback.
  // An out-of-range vc field matches no VC, so the flit vanishes uncounted.
  always_comb begin
    wc_d       = wc_q;
    ws_d       = ws_q;
    len_d      = len_q;
    in_frame_d = in_frame_q;
    skip_d     = skip_q;
    commit     = '0;
    drop_inc   = 1'b0;
    wr_en      = 1'b0;
    wr_vc      = '0;
    wr_addr    = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (acc && in_vc == VCW'(v)) begin
        if (in_sop) begin
          if (in_frame_q[v]) drop_inc = 1'b1;
          wr_en     = 1'b1;
          wr_vc     = VCW'(v);
          wr_addr   = wc_q[v][IW-1:0];
          ws_d[v]   = wc_q[v] + 1'b1;
          len_d[v]  = LW'(1);
          skip_d[v] = 1'b0;
          if (in_eop) begin
            wc_d[v]       = wc_q[v] + 1'b1;
            commit[v]     = 1'b1;
            in_frame_d[v] = 1'b0;
          end else begin
            in_frame_d[v] = 1'b1;
          end
        end else if (!in_frame_q[v]) begin
          // Tail of an oversize frame is discarded without further counting
          if (!skip_q[v]) drop_inc = 1'b1;
        end else if (len_q[v] == LW'(MAX_FRAME_FLITS)) begin
          ws_d[v]       = wc_q[v];
          in_frame_d[v] = 1'b0;
          skip_d[v]     = 1'b1;
          drop_inc      = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_vc    = VCW'(v);
          wr_addr  = ws_q[v][IW-1:0];
          ws_d[v]  = ws_q[v] + 1'b1;
          len_d[v] = len_q[v] + 1'b1;
          if (in_eop) begin
            wc_d[v]       = ws_q[v] + 1'b1;
            commit[v]     = 1'b1;
            in_frame_d[v] = 1'b0;
          end
        end
      end
    end
  end

  // Read side: round-robin pick when idle, hold grant for a whole frame.
  always_comb begin
    r_d         = r_q;
    rd_eop      = '0;
    grant_d     = grant_q;
    grant_vc_d  = grant_vc_q;
    arb_ptr_d   = arb_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    found       = 1'b0;
    pick        = arb_ptr_q;
    sel_avail   = 1'b0;
    sel_entry   = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (!found && fc_q[v] != '0 && v == (32'(arb_ptr_q) + i) % NUM_VC) begin
          found = 1'b1;
          pick  = VCW'(v);
        end
      end
    end
    sel_vc = grant_q ? grant_vc_q : pick;
    sel_ok = grant_q | found;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (VCW'(v) == sel_vc) begin
        sel_avail = (r_q[v] != wc_q[v]);
        sel_entry = mem_q[v][r_q[v][IW-1:0]];
      end
    end
    load = sel_ok & sel_avail & (~out_valid_q | o_ready_in);
    if (out_valid_q && o_ready_in) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d                     = 1'b1;
      out_data_d                      = '0;
      out_data_d[EOP_BIT:0]           = sel_entry[EOP_BIT:0];
      out_data_d[VC_LO +: VCW]        = sel_vc;
      out_data_d[SRC_LO +: AW]        = sel_entry[EW-1 -: AW];
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (VCW'(v) == sel_vc) begin
          r_d[v]    = r_q[v] + 1'b1;
          rd_eop[v] = sel_entry[EOP_BIT];
        end
      end
      if (sel_entry[EOP_BIT]) begin
        grant_d   = 1'b0;
        arb_ptr_d = VCW'((32'(sel_vc) + 1) % NUM_VC);
      end else begin
        grant_d    = 1'b1;
        grant_vc_d = sel_vc;
      end
    end
  end

  // Frame counts, next-cycle ready from next-state occupancy, drop counter.
  always_comb begin
    any_full = 1'b0;
    occ      = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      fc_d[v] = fc_q[v] + PW'(commit[v]) - PW'(rd_eop[v]);
      occ     = ws_d[v] - r_d[v];
      if (occ >= PW'(BUF_DEPTH)) any_full = 1'b1;
    end
    ready_d = ~any_full;
    drop_d  = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  // Buffer storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_vc][wr_addr] <= in_entry;
  end

  // Control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wc_q[v]  <= '0;
        ws_q[v]  <= '0;
        r_q[v]   <= '0;
        fc_q[v]  <= '0;
        len_q[v] <= '0;
      end
      in_frame_q  <= '0;
      skip_q      <= '0;
      grant_q     <= 1'b0;
      grant_vc_q  <= '0;
      arb_ptr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wc_q[v]  <= wc_d[v];
        ws_q[v]  <= ws_d[v];
        r_q[v]   <= r_d[v];
        fc_q[v]  <= fc_d[v];
        len_q[v] <= len_d[v];
      end
      in_frame_q  <= in_frame_d;
      skip_q      <= skip_d;
      grant_q     <= grant_d;
      grant_vc_q  <= grant_vc_d;
      arb_ptr_q   <= arb_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      drop_q      <= drop_d;
    end
  end

endmodule
